// File: rtl/bg_sram_pkg.sv
// Shared types and constants for the background-graphics SRAM sequencer.
package bg_sram_pkg;

  localparam int ADDR_W_DEFAULT = 17;

  typedef enum logic [2:0] {
    IDLE,
    RD0A,
    RD0D,
    RD1A,
    RD1D,
    WRA,
    WRP,
    WRH
  } state_t;

  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_BG = 1'b1
  } grant_t;

  localparam logic LANE_LB = 1'b0;
  localparam logic LANE_UB = 1'b1;

  localparam logic FETCH_W0 = 1'b0;
  localparam logic FETCH_W1 = 1'b1;

  // A tile row occupies two consecutive SRAM words: planes 0/1, then planes 2/3.
  function automatic logic [15:0] fetch_word(input logic [14:0] tile_row, input logic word_sel);
    return {tile_row, word_sel};
  endfunction

endpackage

// File: rtl/bg_sram_wrbuf.sv
// Single-entry download byte buffer: captures qualified strobes, flags drops,
// and releases its contents when the arbiter grants the write.
module bg_sram_wrbuf
  import bg_sram_pkg::*;
(
  input  logic        master_clk,
  input  logic        reset,
  input  logic        strobe,
  input  logic        grant,
  input  logic [17:0] byte_addr,
  input  logic [7:0]  byte_data,
  output logic        full,
  output logic [16:0] word_addr,
  output logic        lane,
  output logic [7:0]  data,
  output logic        busy,
  output logic        overflow
);

  logic        full_reg;
  logic        full_next;
  logic        busy_reg;
  logic        overflow_reg;
  logic [16:0] word_addr_reg;
  logic        lane_reg;
  logic [7:0]  data_reg;
  logic        accept;

  // The grant cycle frees the slot, so a strobe arriving then still fits.
  assign accept = strobe & (~full_reg | grant);

  always_comb begin
    full_next = full_reg;
    if (grant) begin
      full_next = 1'b0;
    end
    if (accept) begin
      full_next = 1'b1;
    end
  end

  always_ff @(posedge master_clk) begin
    if (reset) begin
      full_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
      word_addr_reg <= '0;
      lane_reg      <= LANE_LB;
      data_reg      <= '0;
    end else begin
      full_reg <= full_next;
      // Busy also covers the address-setup cycle of a granted write.
      busy_reg <= full_next | grant;
      if (strobe & ~accept) begin
        overflow_reg <= 1'b1;
      end
      if (accept) begin
        word_addr_reg <= byte_addr[17:1];
        lane_reg      <= byte_addr[0];
        data_reg      <= byte_data;
      end
    end
  end

  assign full      = full_reg;
  assign word_addr = word_addr_reg;
  assign lane      = lane_reg;
  assign data      = data_reg;
  assign busy      = busy_reg;
  assign overflow  = overflow_reg;

endmodule

// File: rtl/bg_sram_arbiter.sv
// Shares the background-graphics SRAM between download byte writes and
// two-word planar tile-row fetches; every SRAM pin is driven from a register.
module bg_sram_arbiter
  import bg_sram_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int BG_BASE = 0
) (
  input  logic              master_clk,
  input  logic              reset,
  input  logic              bg_req,
  input  logic [14:0]       bg_addr,
  output logic              bg_ack,
  output logic [31:0]       bg_data,
  output logic              bg_valid,
  input  logic              dn_wr,
  input  logic              ep5_cs_i,
  input  logic [17:0]       dn_addr,
  input  logic [7:0]        dn_data,
  output logic              dn_busy,
  output logic              dn_overflow,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [15:0]       sram_dq_i,
  output logic [15:0]       sram_dq_o,
  output logic              sram_dq_oe,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BG_BASE);

  state_t              state_reg;
  state_t              state_next;
  grant_t              last_grant_reg;
  logic                grant_bg;
  logic                grant_wr;
  logic [14:0]         fetch_addr_reg;
  logic [15:0]         word0_reg;
  logic [31:0]         bg_data_reg;
  logic                bg_ack_reg;
  logic                bg_valid_reg;

  logic [ADDR_W-1:0]   addr_reg;
  logic [ADDR_W-1:0]   addr_next;
  logic [15:0]         dq_o_reg;
  logic [15:0]         dq_o_next;
  logic                dq_oe_reg;
  logic                dq_oe_next;
  logic                oe_n_reg;
  logic                oe_n_next;
  logic                we_n_reg;
  logic                we_n_next;
  logic                ub_n_reg;
  logic                ub_n_next;
  logic                lb_n_reg;
  logic                lb_n_next;

  logic                wr_full;
  logic [16:0]         wr_word_addr;
  logic                wr_lane;
  logic [7:0]          wr_data;

  bg_sram_wrbuf u_wrbuf (
    .master_clk (master_clk),
    .reset      (reset),
    .strobe     (dn_wr & ep5_cs_i),
    .grant      (grant_wr),
    .byte_addr  (dn_addr),
    .byte_data  (dn_data),
    .full       (wr_full),
    .word_addr  (wr_word_addr),
    .lane       (wr_lane),
    .data       (wr_data),
    .busy       (dn_busy),
    .overflow   (dn_overflow)
  );

  always_ff @(posedge master_clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Pin values are computed for the state being entered, so the registered
  // pins line up exactly with the state they belong to.
  always_comb begin
    state_next = state_reg;
    grant_bg   = 1'b0;
    grant_wr   = 1'b0;
    addr_next  = addr_reg;
    dq_o_next  = dq_o_reg;
    dq_oe_next = 1'b0;
    oe_n_next  = 1'b1;
    we_n_next  = 1'b1;
    ub_n_next  = 1'b1;
    lb_n_next  = 1'b1;

    case (state_reg)
      IDLE: begin
        if (bg_req && (!wr_full || last_grant_reg == GRANT_WR)) begin
          grant_bg   = 1'b1;
          state_next = RD0A;
        end else if (wr_full) begin
          grant_wr   = 1'b1;
          state_next = WRA;
        end
      end
      RD0A:    state_next = RD0D;
      RD0D:    state_next = RD1A;
      RD1A:    state_next = RD1D;
      RD1D:    state_next = IDLE;
      WRA:     state_next = WRP;
      WRP:     state_next = WRH;
      WRH:     state_next = IDLE;
      default: state_next = IDLE;
    endcase

    case (state_next)
      RD0A, RD0D, RD1A, RD1D: begin
        oe_n_next = 1'b0;
        ub_n_next = 1'b0;
        lb_n_next = 1'b0;
      end
      WRA, WRP, WRH: begin
        dq_oe_next = 1'b1;
        we_n_next  = (state_next != WRP);
        ub_n_next  = ub_n_reg;
        lb_n_next  = lb_n_reg;
      end
      default: ;
    endcase

    if (grant_bg) begin
      addr_next = BASE + ADDR_W'(fetch_word(bg_addr, FETCH_W0));
    end
    if (state_reg == RD0D) begin
      addr_next = BASE + ADDR_W'(fetch_word(fetch_addr_reg, FETCH_W1));
    end
    if (grant_wr) begin
      addr_next = BASE + ADDR_W'(wr_word_addr);
      dq_o_next = {wr_data, wr_data};
      ub_n_next = (wr_lane != LANE_UB);
      lb_n_next = (wr_lane != LANE_LB);
    end
  end

  always_ff @(posedge master_clk) begin
    if (reset) begin
      last_grant_reg <= GRANT_WR;
      fetch_addr_reg <= '0;
      word0_reg      <= '0;
      bg_data_reg    <= '0;
      bg_ack_reg     <= 1'b0;
      bg_valid_reg   <= 1'b0;
      addr_reg       <= '0;
      dq_o_reg       <= '0;
      dq_oe_reg      <= 1'b0;
      oe_n_reg       <= 1'b1;
      we_n_reg       <= 1'b1;
      ub_n_reg       <= 1'b1;
      lb_n_reg       <= 1'b1;
    end else begin
      bg_ack_reg   <= grant_bg;
      bg_valid_reg <= (state_reg == RD1D);
      if (grant_bg) begin
        last_grant_reg <= GRANT_BG;
        fetch_addr_reg <= bg_addr;
      end else if (grant_wr) begin
        last_grant_reg <= GRANT_WR;
      end
      if (state_reg == RD0D) begin
        word0_reg <= sram_dq_i;
      end
      if (state_reg == RD1D) begin
        bg_data_reg <= {sram_dq_i, word0_reg};
      end
      addr_reg  <= addr_next;
      dq_o_reg  <= dq_o_next;
      dq_oe_reg <= dq_oe_next;
      oe_n_reg  <= oe_n_next;
      we_n_reg  <= we_n_next;
      ub_n_reg  <= ub_n_next;
      lb_n_reg  <= lb_n_next;
    end
  end

  assign bg_ack     = bg_ack_reg;
  assign bg_valid   = bg_valid_reg;
  assign bg_data    = bg_data_reg;
  assign sram_addr  = addr_reg;
  assign sram_dq_o  = dq_o_reg;
  assign sram_dq_oe = dq_oe_reg;
  assign sram_oe_n  = oe_n_reg;
  assign sram_we_n  = we_n_reg;
  assign sram_ub_n  = ub_n_reg;
  assign sram_lb_n  = lb_n_reg;

endmodule

// File: tb/tb_bg_sram_arbiter.sv
// Scenario bench for bg_sram_arbiter with a transaction-level reference model.
module tb_bg_sram_arbiter;

  localparam int BG_BASE = 0;

  logic        master_clk = 1'b0;
  logic        reset = 1'b1;
  logic        bg_req = 1'b0;
  logic [14:0] bg_addr = '0;
  logic        bg_ack;
  logic [31:0] bg_data;
  logic        bg_valid;
  logic        dn_wr = 1'b0;
  logic        ep5_cs_i = 1'b0;
  logic [17:0] dn_addr = '0;
  logic [7:0]  dn_data = '0;
  logic        dn_busy;
  logic        dn_overflow;
  logic [16:0] sram_addr;
  logic [15:0] sram_dq_i;
  logic [15:0] sram_dq_o;
  logic        sram_dq_oe;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic        sram_ub_n;
  logic        sram_lb_n;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 master_clk = ~master_clk;

  bg_sram_arbiter #(.ADDR_W(17), .BG_BASE(BG_BASE)) dut (
    .master_clk (master_clk),
    .reset      (reset),
    .bg_req     (bg_req),
    .bg_addr    (bg_addr),
    .bg_ack     (bg_ack),
    .bg_data    (bg_data),
    .bg_valid   (bg_valid),
    .dn_wr      (dn_wr),
    .ep5_cs_i   (ep5_cs_i),
    .dn_addr    (dn_addr),
    .dn_data    (dn_data),
    .dn_busy    (dn_busy),
    .dn_overflow(dn_overflow),
    .sram_addr  (sram_addr),
    .sram_dq_i  (sram_dq_i),
    .sram_dq_o  (sram_dq_o),
    .sram_dq_oe (sram_dq_oe),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n),
    .sram_ub_n  (sram_ub_n),
    .sram_lb_n  (sram_lb_n)
  );

  // SRAM contents: two fixed words for the directed fetch, a hash elsewhere.
  function automatic logic [15:0] rd_word(input logic [16:0] a);
    if (a == 17'h02468) return 16'hA1B2;
    if (a == 17'h02469) return 16'hC3D4;
    return {a[7:0] ^ 8'h96, a[15:8] + {4'h0, a[3:0]}};
  endfunction

  assign sram_dq_i = rd_word(sram_addr);

  // Reference model: phase counts cycles since the grant (0 = idle).
  int          m_phase;
  bit          m_wr_kind;
  bit          m_full;
  logic [17:0] m_baddr;
  logic [7:0]  m_bdata;
  bit          m_last_wr;
  logic [14:0] m_faddr;
  logic [15:0] m_w0;
  bit          m_wlane;
  logic        e_ack, e_valid, e_busy, e_ovf, e_dq_oe, e_oe_n, e_we_n, e_ub_n, e_lb_n;
  logic [31:0] e_data;
  logic [16:0] e_addr;
  logic [15:0] e_dq_o;

  logic [73:0] dut_vec;
  logic [73:0] exp_vec;
  assign dut_vec = {bg_ack, bg_valid, bg_data, dn_busy, dn_overflow, sram_addr, sram_dq_o,
                    sram_dq_oe, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n};
  assign exp_vec = {e_ack, e_valid, e_data, e_busy, e_ovf, e_addr, e_dq_o,
                    e_dq_oe, e_oe_n, e_we_n, e_ub_n, e_lb_n};

  task automatic model_reset();
    m_phase = 0; m_wr_kind = 0; m_full = 0; m_baddr = '0; m_bdata = '0;
    m_last_wr = 1; m_faddr = '0; m_w0 = '0; m_wlane = 0;
    e_ack = 0; e_valid = 0; e_data = '0; e_busy = 0; e_ovf = 0; e_addr = '0; e_dq_o = '0;
    e_dq_oe = 0; e_oe_n = 1; e_we_n = 1; e_ub_n = 1; e_lb_n = 1;
  endtask

  task automatic model_step();
    bit g_bg, g_wr, strobe;
    int np;
    logic [17:0] wa;
    logic [7:0] wd;
    if (reset) begin
      model_reset();
      return;
    end
    g_bg = 0;
    g_wr = 0;
    if (m_phase == 0) begin
      if (bg_req && m_full) begin
        g_bg = m_last_wr;
        g_wr = !m_last_wr;
      end else begin
        g_bg = bg_req;
        g_wr = m_full;
      end
    end
    e_valid = (!m_wr_kind && m_phase == 4);
    if (!m_wr_kind && m_phase == 2) m_w0 = rd_word(e_addr);
    if (!m_wr_kind && m_phase == 4) e_data = {rd_word(e_addr), m_w0};
    wa = m_baddr;
    wd = m_bdata;
    strobe = dn_wr && ep5_cs_i;
    if (strobe && m_full && !g_wr) e_ovf = 1;
    else if (strobe) begin
      m_baddr = dn_addr;
      m_bdata = dn_data;
      m_full = 1;
    end else if (g_wr) m_full = 0;
    if (g_bg || g_wr) begin
      np = 1;
      m_wr_kind = g_wr;
      m_last_wr = g_wr;
    end else if (m_phase == 0 || m_phase == (m_wr_kind ? 3 : 4)) np = 0;
    else np = m_phase + 1;
    if (g_bg) m_faddr = bg_addr;
    if (g_wr) begin
      e_dq_o = {wd, wd};
      m_wlane = wa[0];
    end
    e_dq_oe = 0; e_oe_n = 1; e_we_n = 1; e_ub_n = 1; e_lb_n = 1;
    if (np != 0 && !m_wr_kind) begin
      e_addr = 17'(BG_BASE + 2 * int'(m_faddr) + ((np >= 3) ? 1 : 0));
      e_oe_n = 0; e_ub_n = 0; e_lb_n = 0;
    end else if (np != 0) begin
      if (g_wr) e_addr = 17'(BG_BASE + int'(wa) / 2);
      e_dq_oe = 1;
      e_we_n = (np != 2);
      e_ub_n = !m_wlane;
      e_lb_n = m_wlane;
    end
    e_ack = g_bg;
    e_busy = m_full || (m_wr_kind && np == 1);
    m_phase = np;
  endtask

  task automatic tick();
    @(posedge master_clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    reset = 1;
    tick(); tick(); tick();
    checks++;
    if (dut_vec !== exp_vec) begin
      errors++;
      $display("FAIL reset_vec got=%h exp=%h", dut_vec, exp_vec);
    end
    checks++;
    if ({sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe, bg_data} !== {5'b11110, 32'h0}) begin
      errors++;
      $display("FAIL reset_pins got=%b/%h exp=11110/0", {sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe}, bg_data);
    end
    reset = 0;
  endtask

  task automatic test_single_fetch();
    int ack_at = -1;
    int valid_at = -1;
    bg_addr = 15'h1234;
    bg_req = 1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (bg_ack === 1'b1 && ack_at < 0) ack_at = c;
      if (bg_valid === 1'b1 && valid_at < 0) valid_at = c;
      if (e_ack) bg_req = 0;
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL fetch_vec cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
      end
    end
    checks++;
    if (ack_at != 1) begin errors++; $display("FAIL fetch_ack_cycle got=%0d exp=1", ack_at); end
    checks++;
    if (valid_at != 5) begin errors++; $display("FAIL fetch_valid_cycle got=%0d exp=5", valid_at); end
    checks++;
    if (bg_data !== 32'hC3D4A1B2) begin errors++; $display("FAIL fetch_data got=%h exp=c3d4a1b2", bg_data); end
    $display("fetch addr=1234 ack@%0d valid@%0d data=%h", ack_at, valid_at, bg_data);
  endtask

  task automatic test_download();
    int we_low = 0;
    logic [16:0] w_addr = '0;
    logic w_ub = 1'b1;
    logic w_lb = 1'b0;
    logic [15:0] w_dq = '0;
    dn_addr = 18'h00101; dn_data = 8'h5A; dn_wr = 1; ep5_cs_i = 1;
    for (int c = 0; c < 7; c++) begin
      tick();
      dn_wr = 0;
      if (sram_we_n === 1'b0) begin
        we_low++; w_addr = sram_addr; w_ub = sram_ub_n; w_lb = sram_lb_n; w_dq = sram_dq_o;
      end
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL write_vec cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
      end
    end
    checks++;
    if (we_low != 1) begin errors++; $display("FAIL write_we_pulses got=%0d exp=1", we_low); end
    checks++;
    if ({w_addr, w_ub, w_lb, w_dq} !== {17'h00080, 1'b0, 1'b1, 16'h5A5A}) begin
      errors++;
      $display("FAIL write_pins got=addr %h ub %b lb %b dq %h exp=addr 80 ub 0 lb 1 dq 5a5a", w_addr, w_ub, w_lb, w_dq);
    end
    $display("write addr=%h ub_n=%b lb_n=%b dq=%h we_pulses=%0d", w_addr, w_ub, w_lb, w_dq, we_low);
  endtask

  task automatic test_arbitration();
    int seq[$];
    logic prev_oe = 1'b0;
    int bad = 0;
    reset = 1; tick(); reset = 0;
    dn_addr = 18'($urandom); dn_data = 8'($urandom); dn_wr = 1; ep5_cs_i = 1;
    for (int c = 0; c < 45; c++) begin
      tick();
      if (bg_ack === 1'b1) seq.push_back(0);
      if (sram_dq_oe === 1'b1 && prev_oe !== 1'b1) seq.push_back(1);
      prev_oe = sram_dq_oe;
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL arb_vec cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
      end
      bg_req = (c >= 1);
      if (e_ack) bg_addr = 15'($urandom);
      dn_wr = (c >= 2);
      dn_addr = 18'($urandom); dn_data = 8'($urandom);
    end
    bg_req = 0; dn_wr = 0;
    for (int i = 1; i < seq.size(); i++) if (seq[i] == seq[i-1]) bad++;
    checks++;
    if (seq.size() < 6 || seq[0] != 1) begin
      errors++;
      $display("FAIL arb_order got=%0d grants first=%0d exp=>=6 grants first=1(write)", seq.size(), (seq.size() > 0) ? seq[0] : -1);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL arb_alternate got=%0d repeats exp=0", bad); end
    $display("arbitration grants=%0d repeats=%0d", seq.size(), bad);
  endtask

  task automatic drain(input int n, input string tag);
    for (int c = 0; c < n; c++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL %s_vec cyc=%0d got=%h exp=%h", tag, cyc, dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_overflow();
    int we_low = 0;
    reset = 1; tick(); reset = 0;
    bg_addr = 15'($urandom); bg_req = 1;
    tick();
    bg_req = 0;
    dn_addr = 18'h00010; dn_data = 8'h11; dn_wr = 1; ep5_cs_i = 1;
    tick();
    dn_addr = 18'h00021; dn_data = 8'h22;
    tick();
    dn_wr = 0;
    checks++;
    if (dn_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", dn_overflow); end
    drain(10, "ovf");
    checks++;
    if (dn_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", dn_overflow); end
    $display("overflow drop sticky=%b", dn_overflow);

    reset = 1; tick(); reset = 0;
    dn_addr = 18'h00030; dn_data = 8'h33; dn_wr = 1;
    tick();
    dn_addr = 18'h00041; dn_data = 8'h44;
    for (int c = 0; c < 12; c++) begin
      tick();
      dn_wr = 0;
      if (sram_we_n === 1'b0) we_low++;
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL grantcyc_vec cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
      end
    end
    checks++;
    if (dn_overflow !== 1'b0 || we_low != 2) begin
      errors++;
      $display("FAIL grantcyc_accept got=ovf %b writes %0d exp=ovf 0 writes 2", dn_overflow, we_low);
    end
    $display("grant-cycle strobe writes=%0d ovf=%b", we_low, dn_overflow);
  endtask

  task automatic test_reset_mid();
    int valids = 0;
    logic [14:0] a2;
    reset = 1; tick(); reset = 0;
    bg_addr = 15'h0ABC; bg_req = 1;
    tick();
    bg_req = 0;
    drain(6, "pre");
    a2 = 15'($urandom);
    bg_addr = a2; bg_req = 1;
    tick();
    bg_req = 0;
    tick(); tick();
    checks++;
    if (sram_addr !== 17'(2 * int'(a2) + 1)) begin
      errors++;
      $display("FAIL rst_rd1a_addr got=%h exp=%h", sram_addr, 17'(2 * int'(a2) + 1));
    end
    reset = 1;
    tick();
    reset = 0;
    checks++;
    if ({sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe, bg_valid, bg_data} !== {6'b111100, 32'h0}) begin
      errors++;
      $display("FAIL rst_mid_pins got=%b data=%h exp=111100 data=0",
               {sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe, bg_valid}, bg_data);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bg_valid === 1'b1) valids++;
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL rst_mid_vec cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
      end
    end
    checks++;
    if (valids != 0 || bg_data !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_novalid got=valids %0d data %h exp=valids 0 data 0", valids, bg_data);
    end
    $display("reset in RD1A valids=%0d data=%h", valids, bg_data);
  endtask

  task automatic test_back_to_back();
    int acks[$];
    int vals[$];
    int bad = 0;
    bg_addr = 15'($urandom); bg_req = 1;
    for (int c = 1; c <= 22; c++) begin
      tick();
      if (bg_ack === 1'b1) acks.push_back(c);
      if (bg_valid === 1'b1) vals.push_back(c);
      if (e_ack) bg_addr = 15'($urandom);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL b2b_vec cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
      end
    end
    bg_req = 0;
    for (int i = 1; i < acks.size(); i++) begin
      if (acks[i] - acks[i-1] != 5) bad++;
      if (i - 1 < vals.size() && acks[i] != vals[i-1] + 1) bad++;
    end
    checks++;
    if (acks.size() != 5 || acks[0] != 1 || bad != 0) begin
      errors++;
      $display("FAIL b2b_spacing got=%0d acks first=%0d bad=%0d exp=5 acks first=1 bad=0",
               acks.size(), (acks.size() > 0) ? acks[0] : -1, bad);
    end
    drain(6, "b2b_tail");
    $display("back-to-back acks=%0d spacing_errors=%0d", acks.size(), bad);
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 149) == 0);
      if (bg_req && e_ack) bg_req = 0;
      else if (!bg_req && $urandom_range(0, 3) == 0) begin
        bg_req = 1;
        bg_addr = 15'($urandom);
      end
      dn_wr = ($urandom_range(0, 2) == 0);
      ep5_cs_i = ($urandom_range(0, 3) != 0);
      dn_addr = 18'($urandom);
      dn_data = 8'($urandom);
      tick();
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL rand_vec cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
      end
    end
    reset = 0; bg_req = 0; dn_wr = 0;
    drain(8, "rand_tail");
    $display("random cycles=600 done");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_fetch();
    test_download();
    test_arbitration();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
